prince_share_io: RTL and testbench
==================================

# prince_share_io

Host-side load/unload wrapper for the masked PRINCE encryption core (3-share, second-order). It collects plaintext and key shares word-serially over a valid/ready input channel and issues a one-cycle start pulse that drives the core's round controller synchronous reset. It then holds all share registers stable while the core runs, captures the ciphertext shares on the core's done indication, and streams them out over a valid/ready output channel.

## Interface
- SHARES, 3, number of Boolean shares per variable (fixed at 3 for this core)
- W, 64, word width of host channels and of one PRINCE state share
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- in_valid  in  1  host word valid
- in_ready  out  1  wrapper accepts word
- in_data  in  64  share word (order in Operation)
- out_valid  out  1  ciphertext share word valid
- out_ready  in  1  host accepts output word
- out_data  out  64  ciphertext share word
- core_start  out  1  one-cycle pulse, wired to core controller reset
- pt_shares  out  192  {pt2,pt1,pt0} to core, registered
- key_shares  out  384  {key2,key1,key0}, each 128 bits {k0,k1}, registered
- core_done  in  1  core done (combinational from core round counter)
- core_ct  in  192  {ct2,ct1,ct0} from core
- busy  out  1  high whenever not idle-waiting for word 0

## Operation
- States: LOAD, START, RUN, UNLOAD. Reset state LOAD.
- LOAD: in_ready=1. 4-bit word counter wc (0..8). On in_valid&in_ready, word wc is written, wc increments.
  - wc 0..2 -> pt share wc (64 bits).
  - wc 3..5 -> k0 half (bits 127:64) of key share wc-3.
  - wc 6..8 -> k1 half (bits 63:0) of key share wc-6.
  - Accept at wc=8 -> wc clears to 0, next state START.
- START: core_start=1 for exactly this cycle; in_ready=0. Next state RUN.
- RUN: in_ready=0. core_done is ignored in every state except RUN. On the first RUN cycle with core_done=1, core_ct is registered into the ct buffer and the state moves to UNLOAD. core_done held high over several cycles causes no second capture.
- UNLOAD: out_valid=1. 2-bit counter oc (0..2), out_data = ct buffer share oc. On out_valid&out_ready, oc increments. Accept at oc=2 -> oc=0, next state LOAD.
- pt_shares/key_shares change only on LOAD accepts. They are stable from START through the end of UNLOAD.
- Shares are never combined: no XOR across shares anywhere in the block. Each share register is written only from in_data.
- busy = (state != LOAD) | (wc != 0).
- in_valid while in_ready=0 is ignored. in_data is don't-care then.

## Timing
- Reset values: in_ready=1, out_valid=0, core_start=0, busy=0, out_data=0, pt_shares=0, key_shares=0, ct buffer=0, wc=0, oc=0.
- Last input accept at cycle T -> core_start=1 at T+1 -> RUN from T+2.
- core_done first seen high at cycle D (RUN) -> out_valid=1 and out_data=ct0 at D+1.
- Output word i accepted at cycle U -> word i+1 presented at U+1. No bubble when out_ready is held high.
- After the ct2 accept at cycle U, in_ready=1 at U+1.
- All outputs are registered, except in_ready, out_valid and busy, which decode the state register directly.
- Reset mid-operation, in any state: at the next edge all state/counters/data take reset values. Partial loads are discarded and core_start is not issued.
- out_valid, once asserted, stays asserted and out_data stays stable until accepted.

## Test plan
- Full transaction: load words 0x0..0x8 (value = index) with in_valid held high. Expect in_ready to drop after the 9th accept and core_start=1 exactly one cycle later. Expect pt_shares={2,1,0} and key share0 = {0x3,0x6} (k0=0x3, k1=0x6).
- Completion: drive core_done=1 at RUN cycle 5 with core_ct={0xC2,0xC1,0xC0}. Expect out_valid at the next cycle, out_data 0xC0, 0xC1, 0xC2 on successive accepts with out_ready=1, then in_ready=1.
- Backpressure: out_ready=0 for 4 cycles. Expect out_data to hold 0xC0 and out_valid to stay 1. Release -> 0xC1 follows.
- Spurious done: core_done=1 during LOAD and START. No capture and no state change. core_done held high for 3 RUN cycles -> exactly one capture.
- Input gaps: toggle in_valid 1/0 during loading. Exactly 9 accepts before START, and words are mapped to the correct shares.
- Reset mid-RUN and mid-LOAD (after wc=4): the next cycle shows in_ready=1, busy=0, pt_shares=0 and out_valid=0. A subsequent full load completes normally.

Source files
------------

// File: rtl/prince_share_io.sv
// Load/unload wrapper for the 3-share masked PRINCE core: word-serial share
// load, one-cycle core start, ciphertext capture on done, word-serial unload.
module prince_share_io #(
  parameter int SHARES = 3,
  parameter int W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  core_start,
  output logic [SHARES*W-1:0]   pt_shares,
  output logic [SHARES*2*W-1:0] key_shares,
  input  logic                  core_done,
  input  logic [SHARES*W-1:0]   core_ct,
  output logic                  busy
);

  typedef enum logic [1:0] {LOAD, START, RUN, UNLOAD} state_t;

  localparam logic [3:0] LAST_WORD  = 4'(3*SHARES-1);
  localparam logic [1:0] LAST_SHARE = 2'(SHARES-1);

  state_t state, stateNext;
  logic [3:0] wc;
  logic [1:0] oc;
  logic [SHARES-1:0][W-1:0] pt, k0, k1, ctBuf;
  logic [W-1:0] outData;
  logic coreStart;
  logic inAcc, outAcc, capture;

  assign inAcc   = in_valid & in_ready;
  assign outAcc  = out_valid & out_ready;
  assign capture = (state == RUN) & core_done;

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wc == LAST_WORD) stateNext = START;
      end
      START:  stateNext = RUN;
      RUN:    if (core_done) stateNext = UNLOAD;
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && oc == LAST_SHARE) stateNext = LOAD;
      end
      default: stateNext = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      wc        <= '0;
      oc        <= '0;
      coreStart <= 1'b0;
      outData   <= '0;
    end else begin
      state     <= stateNext;
      coreStart <= inAcc && (wc == LAST_WORD);
      if (inAcc) wc <= (wc == LAST_WORD) ? 4'd0 : wc + 4'd1;
      if (outAcc) oc <= (oc == LAST_SHARE) ? 2'd0 : oc + 2'd1;
      // Output word is registered: load ct0 on capture, then the next share per accept
      if (capture) outData <= core_ct[W-1:0];
      else if (outAcc && oc != LAST_SHARE) outData <= ctBuf[oc + 2'd1];
    end
  end

  // Each share register is loaded only from in_data / core_ct; shares never mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      pt    <= '0;
      k0    <= '0;
      k1    <= '0;
      ctBuf <= '0;
    end else begin
      for (int s = 0; s < SHARES; s++) begin
        if (inAcc && wc == 4'(s))            pt[s] <= in_data;
        if (inAcc && wc == 4'(SHARES + s))   k0[s] <= in_data;
        if (inAcc && wc == 4'(2*SHARES + s)) k1[s] <= in_data;
        if (capture) ctBuf[s] <= core_ct[s*W +: W];
      end
    end
  end

  for (genvar s = 0; s < SHARES; s++) begin : g_key
    assign key_shares[s*2*W +: 2*W] = {k0[s], k1[s]};
  end

  assign pt_shares  = pt;
  assign out_data   = outData;
  assign core_start = coreStart;
  assign busy       = (state != LOAD) | (wc != 4'd0);

endmodule

// File: tb/tb_prince_share_io.sv
// Scoreboard bench for prince_share_io: ciphertext words are queued when the
// core done is driven and popped as the wrapper unloads them.
module tb_prince_share_io;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         core_start;
  logic [191:0] pt_shares;
  logic [383:0] key_shares;
  logic         core_done;
  logic [191:0] core_ct;
  logic         busy;

  int nCmp = 0;
  int nErr = 0;
  logic [63:0] sb[$];

  prince_share_io #(.SHARES(3), .W(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .pt_shares(pt_shares), .key_shares(key_shares),
    .core_done(core_done), .core_ct(core_ct), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_core_start"}, 128'(core_start), 128'(0));
    chk({tag, "_pt_lo"}, 128'(pt_shares[127:0]), 128'(0));
    chk({tag, "_pt_hi"}, 128'(pt_shares[191:128]), 128'(0));
  endtask

  task automatic chkShares(input string tag, input logic [63:0] w[9]);
    for (int s = 0; s < 3; s++) begin
      chk({tag, "_pt"}, 128'(pt_shares[s*64 +: 64]), 128'(w[s]));
      chk({tag, "_key"}, key_shares[s*128 +: 128], {w[3+s], w[6+s]});
    end
  endtask

  // Presents words until n accepts; optional random gaps and spurious done.
  task automatic loadWords(input logic [63:0] w[9], input int n, input bit gaps, input bit spur);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 200) begin
      in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = in_valid ? w[i] : 64'hDEAD_0000_0000_0000 | 64'(guard);
      core_done = spur;
      core_ct   = {3{64'hBAD0_BAD0_BAD0_BAD0}};
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      guard++;
      if (i < 9) chk("load_in_ready", 128'(in_ready), 128'(1));
    end
    in_valid  = 1'b0;
    core_done = 1'b0;
    if (guard >= 200) chk("load_timeout", 128'(i), 128'(n));
  endtask

  // Called in the START cycle; leaves the bench in the first RUN cycle.
  task automatic afterLoad(input bit spur);
    chk("start_in_ready", 128'(in_ready), 128'(0));
    chk("start_pulse", 128'(core_start), 128'(1));
    chk("start_busy", 128'(busy), 128'(1));
    core_done = spur;
    core_ct   = {3{64'hBAD1_BAD1_BAD1_BAD1}};
    step();
    core_done = 1'b0;
    chk("run_pulse_gone", 128'(core_start), 128'(0));
    chk("run_no_capture", 128'(out_valid), 128'(0));
  endtask

  task automatic runCore(input logic [63:0] c0, c1, c2, input int waitCyc, input int hold);
    for (int k = 0; k < waitCyc; k++) begin
      in_valid = 1'b1;
      in_data  = 64'hFFFF_0000_FFFF_0000;
      step();
      chk("run_wait_ov", 128'(out_valid), 128'(0));
    end
    in_valid  = 1'b0;
    core_done = 1'b1;
    core_ct   = {c2, c1, c0};
    sb.push_back(c0);
    sb.push_back(c1);
    sb.push_back(c2);
    step();
    chk("done_ov", 128'(out_valid), 128'(1));
    for (int h = 1; h < hold; h++) begin
      core_ct = ~{c2, c1, c0};
      step();
    end
    core_done = 1'b0;
  endtask

  task automatic unload(input int bp);
    logic [63:0] exp;
    int guard;
    for (int wd = 0; wd < 3; wd++) begin
      out_ready = 1'b0;
      if (wd == 0) begin
        for (int b = 0; b < bp; b++) begin
          step();
          chk("bp_ov", 128'(out_valid), 128'(1));
          chk("bp_data", 128'(out_data), 128'(sb.size() > 0 ? sb[0] : 64'h0));
        end
      end
      guard = 0;
      while (!out_valid && guard < 20) begin
        step();
        guard++;
      end
      chk("unload_ov", 128'(out_valid), 128'(1));
      if (sb.size() == 0) begin
        chk("sb_empty", 128'(1), 128'(0));
        exp = '0;
      end else exp = sb.pop_front();
      chk("unload_data", 128'(out_data), 128'(exp));
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("post_unload_in_ready", 128'(in_ready), 128'(1));
    chk("post_unload_ov", 128'(out_valid), 128'(0));
    chk("post_unload_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [63:0] w1[9];
    logic [63:0] w2[9];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    core_done = 1'b0;
    core_ct   = '0;
    for (int i = 0; i < 9; i++) begin
      w1[i] = 64'(i);
      w2[i] = {$urandom, $urandom};
    end
    step();
    step();
    reset = 1'b0;

    chkIdle("rst");
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_key", key_shares[127:0], 128'(0));

    // Plain transaction, done at RUN cycle 5
    loadWords(w1, 9, 1'b0, 1'b0);
    afterLoad(1'b0);
    chkShares("tx1", w1);
    chk("tx1_key0", key_shares[127:0], {64'h3, 64'h6});
    runCore(64'hC0, 64'hC1, 64'hC2, 4, 1);
    unload(0);
    chkShares("tx1_hold", w1);

    // Gaps, spurious done in LOAD/START, done held 3 cycles, backpressure
    loadWords(w2, 9, 1'b1, 1'b1);
    afterLoad(1'b1);
    chkShares("tx2", w2);
    runCore(64'hA0A0, 64'hA1A1, 64'hA2A2, 2, 3);
    unload(4);
    chkShares("tx2_hold", w2);

    // Reset mid-RUN
    loadWords(w1, 9, 1'b0, 1'b0);
    afterLoad(1'b0);
    step();
    doReset();
    chkIdle("rst_run");

    // Reset mid-LOAD after four words
    loadWords(w2, 4, 1'b0, 1'b0);
    chk("partial_busy", 128'(busy), 128'(1));
    doReset();
    chkIdle("rst_load");

    loadWords(w2, 9, 1'b0, 1'b0);
    afterLoad(1'b0);
    chkShares("tx3", w2);
    runCore(64'h1111, 64'h2222, 64'h3333, 0, 1);
    unload(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
